// File: rtl/reflet_bus_ctrl_if.sv
// CPU-side and slave-side signals of the reflet system bus, grouped for the bus controller.
// REFLET_BUS_ERROR_STICKY_EN adds error_addr to the bundle.
interface reflet_bus_ctrl_if #(
    parameter int wordsize = 16,
    parameter int n_slaves = 3
);
    logic [wordsize-1:0]          cpu_addr;
    logic [wordsize-1:0]          cpu_data_out;
    logic                         cpu_write_en;
    logic [wordsize-1:0]          cpu_data_in;
    logic                         pm_enable;
    logic                         cpu_enable;
    logic [n_slaves-1:0]          slave_sel;
    logic [wordsize-1:0]          slave_addr;
    logic [wordsize-1:0]          slave_wdata;
    logic [n_slaves-1:0]          slave_write_en;
    logic [n_slaves*wordsize-1:0] slave_rdata;
    logic                         bus_error;

`ifdef REFLET_BUS_ERROR_STICKY_EN
    logic [wordsize-1:0]          error_addr;

    modport master (
        output cpu_addr, cpu_data_out, cpu_write_en, pm_enable, slave_rdata,
        input  cpu_data_in, cpu_enable, slave_sel, slave_addr, slave_wdata,
        input  slave_write_en, bus_error, error_addr
    );

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_write_en, pm_enable, slave_rdata,
        output cpu_data_in, cpu_enable, slave_sel, slave_addr, slave_wdata,
        output slave_write_en, bus_error, error_addr
    );
`else
    modport master (
        output cpu_addr, cpu_data_out, cpu_write_en, pm_enable, slave_rdata,
        input  cpu_data_in, cpu_enable, slave_sel, slave_addr, slave_wdata,
        input  slave_write_en, bus_error
    );

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_write_en, pm_enable, slave_rdata,
        output cpu_data_in, cpu_enable, slave_sel, slave_addr, slave_wdata,
        output slave_write_en, bus_error
    );
`endif
endinterface

// File: rtl/reflet_bus_ctrl.sv
// Mask/base region decoder with per-region wait states for the reflet CPU system bus.
// Optional feature macro: REFLET_BUS_ERROR_STICKY_EN (sticky bus_error plus error_addr capture).
module reflet_bus_ctrl #(
    parameter int                           wordsize   = 16,
    parameter int                           n_slaves   = 3,
    parameter logic [n_slaves*wordsize-1:0] slave_base = {16'h0000, 16'h8000, 16'hFF00},
    parameter logic [n_slaves*wordsize-1:0] slave_mask = {16'h8000, 16'h8000, 16'hFF00},
    parameter logic [n_slaves*4-1:0]        slave_wait = {4'd0, 4'd1, 4'd0}
) (
    input logic              clk,
    input logic              reset,
    reflet_bus_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_s;
    logic [2:0]          region_r;
    logic [2:0]          region_s;
    logic                wr_r;
    logic                wr_s;

    logic                hit_s;
    logic [2:0]          idx_s;
    logic [3:0]          wait_s;
    logic                stall_s;
    logic                cur_hit_s;
    logic [2:0]          cur_idx_s;
    logic                cur_wr_s;
    logic [n_slaves-1:0] sel_s;
    logic [wordsize-1:0] rdata_s;

    // address decode; scanning downwards lets the lowest matching index win
    always_comb begin
        hit_s = 1'b0;
        idx_s = 3'd0;
        for (int i = n_slaves - 1; i >= 0; i--) begin
            if ((bus.cpu_addr & slave_mask[i*wordsize +: wordsize]) == slave_base[i*wordsize +: wordsize]) begin
                hit_s = 1'b1;
                idx_s = 3'(i);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // wait-state count of the freshly decoded region
    always_comb begin
        wait_s = 4'd0;
        for (int i = 0; i < n_slaves; i++) begin
            if (idx_s == 3'(i)) begin
                wait_s = slave_wait[i*4 +: 4];
            end else begin
                wait_s = wait_s;
            end
        end
    end

    // next state, stall and which region/write flag drive the bus this cycle
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        region_s  = region_r;
        wr_s      = wr_r;
        stall_s   = 1'b0;
        cur_hit_s = hit_s;
        cur_idx_s = idx_s;
        cur_wr_s  = bus.cpu_write_en;
        case (state_r)
            IDLE: begin
                if (!reset && hit_s && (wait_s != 4'd0) && bus.pm_enable) begin
                    stall_s  = 1'b1;
                    state_s  = WAIT;
                    cnt_s    = wait_s - 4'd1;
                    region_s = idx_s;
                    wr_s     = bus.cpu_write_en;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                // the CPU is frozen, so the latched access is what the slaves see
                cur_hit_s = 1'b1;
                cur_idx_s = region_r;
                cur_wr_s  = wr_r;
                stall_s   = (cnt_r != 4'd0) && !reset;
                if (bus.pm_enable && (cnt_r == 4'd0)) begin
                    state_s = IDLE;
                end else if (bus.pm_enable) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // state register, wait counter and latched access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            region_r <= 3'd0;
            wr_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            region_r <= region_s;
            wr_r     <= wr_s;
        end
    end

    // one-hot select and read-data steering from the active region
    always_comb begin
        sel_s   = {n_slaves{1'b0}};
        rdata_s = {wordsize{1'b0}};
        for (int i = 0; i < n_slaves; i++) begin
            if (cur_hit_s && (cur_idx_s == 3'(i))) begin
                sel_s[i] = 1'b1;
                rdata_s  = bus.slave_rdata[i*wordsize +: wordsize];
            end else begin
                sel_s[i] = 1'b0;
            end
        end
    end

    assign bus.slave_sel      = sel_s;
    assign bus.cpu_data_in    = rdata_s;
    assign bus.slave_addr     = bus.cpu_addr;
    assign bus.slave_wdata    = bus.cpu_data_out;
    assign bus.cpu_enable     = bus.pm_enable & ~stall_s;
    assign bus.slave_write_en = sel_s & {n_slaves{cur_wr_s & ~stall_s & bus.pm_enable & ~reset}};

`ifdef REFLET_BUS_ERROR_STICKY_EN
    logic                err_r;
    logic [wordsize-1:0] err_addr_r;

    // remember the first unmapped access until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r      <= 1'b0;
            err_addr_r <= {wordsize{1'b0}};
        end else if (!cur_hit_s && !err_r) begin
            err_r      <= 1'b1;
            err_addr_r <= bus.cpu_addr;
        end else begin
            err_r      <= err_r;
            err_addr_r <= err_addr_r;
        end
    end

    assign bus.bus_error  = err_r;
    assign bus.error_addr = err_addr_r;
`else
    assign bus.bus_error  = ~cur_hit_s & ~reset;
`endif

endmodule
